// File: rtl/pid_pkg.sv
// pid_pkg: FSM state encoding and parameter legality check shared by the PID controller files
package pid_pkg;
    typedef enum logic [2:0] {IDLE, ERR, MP, MI, MD, SUM, OUT} state_t;
    function automatic bit accw_ok(input int w, input int accw);
        return accw >= 2 * w + 2;
    endfunction
endpackage

// File: rtl/pid_sat.sv
// pid_sat: signed narrowing saturator IW -> OW bits with a clamped flag
// Ports: din (IW signed in), dout (OW signed out, clamped to [-2^(OW-1), 2^(OW-1)-1]), clamped (1 when din was out of range)
module pid_sat #(
    parameter int IW = 17,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout,
    output logic                 clamped
);
    localparam logic signed [IW-1:0] MAX_I = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW-1:0] MIN_I = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    localparam logic signed [OW-1:0] MAX_O = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] MIN_O = {1'b1, {(OW-1){1'b0}}};
    logic hi, lo;
    always_comb begin
        hi = din > MAX_I;
        lo = din < MIN_I;
        dout = hi ? MAX_O : lo ? MIN_O : din[OW-1:0];
        clamped = hi | lo;
    end
endmodule

// File: rtl/pid_ctrl_param.sv
// pid_ctrl_param: sample-strobed positional PID (u = P + I + D) on one time-shared signed multiplier
// Ports: i_clk, i_rst (sync, active-high), i_start (sample strobe), i_clr (clear I and e_prev),
//        sp, pv, kp, ki, kd (W signed, gains Q(W-FRAC).FRAC), o_un (W signed saturated output),
//        o_valid (o_un update pulse), o_busy (sample in flight), o_sat (o_un clamped)
// Build option: define PID_ANTIWINDUP_EN for conditional integration while the output is clamped.
module pid_ctrl_param
    import pid_pkg::*;
#(
    parameter int W    = 16,
    parameter int FRAC = 8,
    parameter int ACCW = 36
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_clr,
    input  logic signed [W-1:0] sp,
    input  logic signed [W-1:0] pv,
    input  logic signed [W-1:0] kp,
    input  logic signed [W-1:0] ki,
    input  logic signed [W-1:0] kd,
    output logic signed [W-1:0] o_un,
    output logic                o_valid,
    output logic                o_busy,
    output logic                o_sat
);
    if (!accw_ok(W, ACCW)) begin : g_bad_accw
        $error("pid_ctrl_param: ACCW must be >= 2*W+2");
    end

    state_t state, state_nx;
    logic signed [W-1:0]    sp_r, pv_r, kp_r, ki_r, kd_r, e_r, de_r, e_prev;
    logic signed [W-1:0]    mul_a, mul_b, e_w, de_w, un_w;
    logic signed [2*W-1:0]  prod, prod_sh;
    logic signed [ACCW-1:0] prod_x, p_r, icand, acc, i_r, ic_w, acc_w;
    logic signed [W:0]      e_diff, de_diff;
    logic signed [ACCW:0]   ic_sum;
    logic signed [ACCW+1:0] acc_sum;
    logic                   e_cl, de_cl, ic_cl, acc_cl, un_cl, hold;
    logic                   unused;

    always_comb begin
        state_nx = state == IDLE ? (i_start ? ERR : IDLE)
                 : state == OUT  ? IDLE
                 : state_t'(state + 3'd1);
        o_busy = state != IDLE;
        mul_a = state == MI ? ki_r : state == MD ? kd_r : kp_r;
        mul_b = state == MD ? de_r : e_r;
        prod_sh = prod >>> FRAC;
        prod_x = {{(ACCW-2*W){prod_sh[2*W-1]}}, prod_sh};
        e_diff = {sp_r[W-1], sp_r} - {pv_r[W-1], pv_r};
        de_diff = {e_w[W-1], e_w} - {e_prev[W-1], e_prev};
        ic_sum = {i_r[ACCW-1], i_r} + {prod_x[ACCW-1], prod_x};
        acc_sum = {{2{p_r[ACCW-1]}}, p_r} + {{2{icand[ACCW-1]}}, icand}
                + {{2{prod_x[ACCW-1]}}, prod_x};
`ifdef PID_ANTIWINDUP_EN
        // freeze the integrator only when it would push further into the clamp
        hold = un_cl && (acc[ACCW-1] ? icand < i_r : icand > i_r);
`else
        hold = 1'b0;
`endif
    end

    pid_sat #(.IW(W+1),    .OW(W))    u_sat_e   (.din(e_diff),  .dout(e_w),   .clamped(e_cl));
    pid_sat #(.IW(W+1),    .OW(W))    u_sat_de  (.din(de_diff), .dout(de_w),  .clamped(de_cl));
    pid_sat #(.IW(ACCW+1), .OW(ACCW)) u_sat_ic  (.din(ic_sum),  .dout(ic_w),  .clamped(ic_cl));
    pid_sat #(.IW(ACCW+2), .OW(ACCW)) u_sat_acc (.din(acc_sum), .dout(acc_w), .clamped(acc_cl));
    pid_sat #(.IW(ACCW),   .OW(W))    u_sat_un  (.din(acc),     .dout(un_w),  .clamped(un_cl));

    assign unused = ^{e_cl, de_cl, ic_cl, acc_cl};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            o_un    <= '0;
            o_valid <= 1'b0;
            o_sat   <= 1'b0;
            i_r     <= '0;
            e_prev  <= '0;
        end else begin
            state   <= state_nx;
            o_valid <= state == OUT;
            if (state == IDLE && i_clr) begin
                i_r    <= '0;
                e_prev <= '0;
            end
            if (state == IDLE && i_start) begin
                sp_r <= sp;
                pv_r <= pv;
                kp_r <= kp;
                ki_r <= ki;
                kd_r <= kd;
            end
            if (state == ERR) begin
                e_r  <= e_w;
                de_r <= de_w;
            end
            if (state == MP || state == MI || state == MD) prod <= mul_a * mul_b;
            if (state == MI) p_r <= prod_x;
            if (state == MD) icand <= ic_w;
            if (state == SUM) acc <= acc_w;
            if (state == OUT) begin
                o_un   <= un_w;
                o_sat  <= un_cl;
                e_prev <= e_r;
                if (!hold) i_r <= icand;
            end
        end
    end
endmodule

// File: tb/tb_pid_ctrl_param.sv
// tb_pid_ctrl_param: directed self-checking bench for pid_ctrl_param against an arithmetic PID model
module tb_pid_ctrl_param;
    localparam int W = 16, FRAC = 8, ACCW = 36;

    logic i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_clr = 1'b0;
    logic signed [W-1:0] sp = '0, pv = '0, kp = '0, ki = '0, kd = '0;
    logic signed [W-1:0] o_un;
    logic o_valid, o_busy, o_sat;

    pid_ctrl_param #(.W(W), .FRAC(FRAC), .ACCW(ACCW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_clr(i_clr),
        .sp(sp), .pv(pv), .kp(kp), .ki(ki), .kd(kd),
        .o_un(o_un), .o_valid(o_valid), .o_busy(o_busy), .o_sat(o_sat)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {int due; longint un; bit sat;} res_t;
    res_t q[$];
    int checks = 0, passed = 0, nc = 0, acc_at = -100;
    longint m_i = 0, m_ep = 0, exp_un = 0;
    bit exp_sat = 1'b0;

    function automatic longint clampn(input longint v, input int n);
        longint hi, lo;
        hi = (longint'(1) <<< (n - 1)) - 1;
        lo = -hi - 1;
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    endtask

    always @(negedge i_clk) begin
        nc++;
        if (q.size() > 0 && q[0].due == nc) begin
            check("valid_pulse", longint'(o_valid), 1);
            exp_un = q[0].un;
            exp_sat = q[0].sat;
            void'(q.pop_front());
        end else begin
            check("valid_idle", longint'(o_valid), 0);
        end
        check("busy", longint'(o_busy), longint'(nc > acc_at && nc <= acc_at + 6));
        check("o_un", longint'(o_un), exp_un);
        check("o_sat", longint'(o_sat), longint'(exp_sat));
    end

    task automatic sample(input int s, input int p, input int gp, input int gi, input int gd, input bit clr);
        longint e, de, ic, a, u;
        @(negedge i_clk); #1;
        sp = W'(s); pv = W'(p); kp = W'(gp); ki = W'(gi); kd = W'(gd);
        i_start = 1'b1; i_clr = clr;
        if (clr) begin m_i = 0; m_ep = 0; end
        e  = clampn(longint'(s - p), W);
        de = clampn(e - m_ep, W);
        ic = clampn(m_i + ((longint'(gi) * e) >>> FRAC), ACCW);
        a  = clampn(((longint'(gp) * e) >>> FRAC) + ic + ((longint'(gd) * de) >>> FRAC), ACCW);
        u  = clampn(a, W);
`ifdef PID_ANTIWINDUP_EN
        if (!(u != a && ((a > 0 && ic > m_i) || (a < 0 && ic < m_i)))) m_i = ic;
`else
        m_i = ic;
`endif
        m_ep = e;
        q.push_back('{nc + 7, u, u != a});
        acc_at = nc;
        @(negedge i_clk); #1;
        i_start = 1'b0; i_clr = 1'b0;
    endtask

    task automatic settle();
        repeat (7) @(negedge i_clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge i_clk);
        #1;
        check("rst_un", longint'(o_un), 0);
        check("rst_busy", longint'(o_busy), 0);
        i_rst = 1'b0;

        sample(100, 40, 'h0100, 0, 0, 1'b0); settle();
        check("p_only", longint'(o_un), 60);
        check("p_only_sat", longint'(o_sat), 0);

        sample(10, 0, 0, 'h0080, 0, 1'b1); settle(); check("int_1", longint'(o_un), 5);
        sample(10, 0, 0, 'h0080, 0, 1'b0); settle(); check("int_2", longint'(o_un), 10);
        sample(10, 0, 0, 'h0080, 0, 1'b0); settle(); check("int_3", longint'(o_un), 15);
        sample(10, 0, 0, 'h0080, 0, 1'b1); settle(); check("int_clr", longint'(o_un), 5);

        sample(10, 0, 0, 0, 'h0100, 1'b1); settle(); check("der_1", longint'(o_un), 10);
        sample(30, 0, 0, 0, 'h0100, 1'b0); settle(); check("der_2", longint'(o_un), 20);

        for (int k = 0; k < 4; k++) begin
            sample(1000, 0, 'h7FFF, 'h0100, 0, k == 0); settle();
            check("sat_un", longint'(o_un), 32767);
            check("sat_flag", longint'(o_sat), 1);
        end
`ifdef PID_ANTIWINDUP_EN
        check("aw_model_i", m_i, 0);
        sample(0, 0, 0, 'h0100, 0, 1'b0); settle(); check("aw_after", longint'(o_un), 0);
`else
        check("aw_model_i", m_i, 4000);
        sample(0, 0, 0, 'h0100, 0, 1'b0); settle(); check("aw_after", longint'(o_un), 4000);
`endif
        check("aw_after_sat", longint'(o_sat), 0);

        sample(100, 40, 'h0100, 0, 0, 1'b1);
        @(negedge i_clk); #1;
        sp = 16'sd500; i_start = 1'b1;
        @(negedge i_clk); #1;
        i_start = 1'b0;
        repeat (10) @(negedge i_clk);
        #1;
        check("busy_ignore", longint'(o_un), 60);

        sample(300, 40, 'h0100, 0, 0, 1'b1);
        repeat (2) @(negedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        q.delete();
        acc_at = -100;
        exp_un = 0; exp_sat = 1'b0; m_i = 0; m_ep = 0;
        i_rst = 1'b0;
        @(negedge i_clk); #1;
        check("abort_un", longint'(o_un), 0);
        check("abort_busy", longint'(o_busy), 0);
        repeat (8) @(negedge i_clk);
        #1;
        check("abort_quiet", longint'(o_un), 0);
        sample(100, 40, 'h0100, 0, 0, 1'b0); settle();
        check("post_abort", longint'(o_un), 60);

        repeat (3) @(negedge i_clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
